// File: rtl/spi_slave_shifter.sv
// SPI slave endpoint: oversamples SCLK/MOSI/SSbar in the clk domain and shifts rx/tx words MSB first.
// Optional build macro SPI_SLAVE_RX_OVERRUN_EN adds a sticky rx_overrun flag and keeps unread rx_data.
module spi_slave_shifter #(
  parameter int unsigned WORD_LENGTH = 8,
  parameter bit          CPOL        = 1'b0,
  parameter bit          CPHA        = 1'b0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   SCLK,
  input  logic                   MOSI,
  input  logic                   SSbar,
  output logic                   MISO,
  output logic                   miso_oe,
  input  logic [WORD_LENGTH-1:0] tx_data,
  input  logic                   tx_load,
  output logic                   tx_empty,
  output logic [WORD_LENGTH-1:0] rx_data,
  output logic                   rx_valid,
  input  logic                   rx_ack,
  output logic                   busy
`ifdef SPI_SLAVE_RX_OVERRUN_EN
  ,
  output logic                   rx_overrun
`endif
);

  localparam int unsigned CntW = (WORD_LENGTH > 1) ? $clog2(WORD_LENGTH) : 1;
  localparam logic [CntW-1:0] CntTop = CntW'(WORD_LENGTH - 1);

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StShift,
    StDone
  } state_e;

  state_e r_state;
  state_e w_state_next;

  logic r_sclk_s1, r_sclk_s2, r_sclk_s3;
  logic r_mosi_s1, r_mosi_s2;
  logic r_ss_s1, r_ss_s2;

  logic [WORD_LENGTH-1:0] r_tx_hold;
  logic                   r_tx_empty;
  logic [WORD_LENGTH-1:0] r_tx_shift;
  logic                   r_miso;
  logic [WORD_LENGTH-1:0] r_rx_shift;
  logic [WORD_LENGTH-1:0] r_rx_data;
  logic                   r_rx_valid;
  logic [CntW-1:0]        r_bit_cnt;
`ifdef SPI_SLAVE_RX_OVERRUN_EN
  logic                   r_rx_overrun;
`endif

  logic                   w_rise, w_fall, w_lead, w_trail;
  logic                   w_sample, w_drive;
  logic                   w_busy;
  logic [WORD_LENGTH-1:0] w_load_word;

  // Synchronisers; SCLK idles at CPOL so reset release never looks like an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sclk_s1 <= CPOL;
      r_sclk_s2 <= CPOL;
      r_sclk_s3 <= CPOL;
      r_mosi_s1 <= 1'b0;
      r_mosi_s2 <= 1'b0;
      r_ss_s1   <= 1'b1;
      r_ss_s2   <= 1'b1;
    end else begin
      r_sclk_s1 <= SCLK;
      r_sclk_s2 <= r_sclk_s1;
      r_sclk_s3 <= r_sclk_s2;
      r_mosi_s1 <= MOSI;
      r_mosi_s2 <= r_mosi_s1;
      r_ss_s1   <= SSbar;
      r_ss_s2   <= r_ss_s1;
    end
  end

  assign w_rise   = r_sclk_s2 & ~r_sclk_s3;
  assign w_fall   = ~r_sclk_s2 & r_sclk_s3;
  assign w_lead   = CPOL ? w_fall : w_rise;
  assign w_trail  = CPOL ? w_rise : w_fall;
  assign w_sample = CPHA ? w_trail : w_lead;
  // With CPHA=0 the MSB is already out after LOAD; the first trailing edge of a word
  // (the previous word's last one when back-to-back) must not shift again.
  assign w_drive  = CPHA ? w_lead : (w_trail && (r_bit_cnt != CntTop));

  assign w_load_word = tx_load ? tx_data : (r_tx_empty ? '0 : r_tx_hold);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_busy       = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (!r_ss_s2) begin
          w_state_next = StLoad;
        end
      end
      StLoad: begin
        w_busy       = 1'b1;
        w_state_next = StShift;
      end
      StShift: begin
        w_busy = 1'b1;
        if (r_ss_s2) begin
          w_state_next = StIdle;
        end else if (w_sample && (r_bit_cnt == '0)) begin
          w_state_next = StDone;
        end
      end
      StDone: begin
        w_busy       = 1'b1;
        w_state_next = r_ss_s2 ? StIdle : StLoad;
      end
      default: begin
        w_state_next = StIdle;
      end
    endcase
  end

  // Transmit path: holding register, shift register and registered MISO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tx_hold  <= '0;
      r_tx_empty <= 1'b1;
      r_tx_shift <= '0;
      r_miso     <= 1'b0;
    end else begin
      if (tx_load) begin
        r_tx_hold  <= tx_data;
        r_tx_empty <= 1'b0;
      end
      unique case (r_state)
        StIdle: begin
          r_miso <= 1'b0;
        end
        StLoad: begin
          r_tx_empty <= 1'b1;
          if (CPHA) begin
            r_tx_shift <= w_load_word;
          end else begin
            r_tx_shift <= w_load_word << 1;
            r_miso     <= w_load_word[WORD_LENGTH-1];
          end
        end
        StShift: begin
          if (r_ss_s2) begin
            r_miso     <= 1'b0;
            r_tx_shift <= '0;
          end else if (w_drive) begin
            r_miso     <= r_tx_shift[WORD_LENGTH-1];
            r_tx_shift <= r_tx_shift << 1;
          end
        end
        default: ;
      endcase
    end
  end

  // Receive path: sample shift register, bit counter and the rx word handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_shift   <= '0;
      r_bit_cnt    <= CntTop;
      r_rx_data    <= '0;
      r_rx_valid   <= 1'b0;
`ifdef SPI_SLAVE_RX_OVERRUN_EN
      r_rx_overrun <= 1'b0;
`endif
    end else begin
      if (rx_ack) begin
        r_rx_valid   <= 1'b0;
`ifdef SPI_SLAVE_RX_OVERRUN_EN
        r_rx_overrun <= 1'b0;
`endif
      end
      unique case (r_state)
        StShift: begin
          if (r_ss_s2) begin
            r_rx_shift <= '0;
            r_bit_cnt  <= CntTop;
          end else if (w_sample) begin
            r_rx_shift <= {r_rx_shift[WORD_LENGTH-2:0], r_mosi_s2};
            r_bit_cnt  <= r_bit_cnt - CntW'(1);
          end
        end
        StDone: begin
          r_bit_cnt <= CntTop;
`ifdef SPI_SLAVE_RX_OVERRUN_EN
          // An unread word is kept; a same-cycle ack frees the slot for the new one.
          if (r_rx_valid && !rx_ack) begin
            r_rx_overrun <= 1'b1;
          end else begin
            r_rx_data  <= r_rx_shift;
            r_rx_valid <= 1'b1;
          end
`else
          r_rx_data  <= r_rx_shift;
          r_rx_valid <= 1'b1;
`endif
        end
        default: ;
      endcase
    end
  end

  assign MISO     = r_miso;
  assign miso_oe  = w_busy;
  assign busy     = w_busy;
  assign tx_empty = r_tx_empty;
  assign rx_data  = r_rx_data;
  assign rx_valid = r_rx_valid;
`ifdef SPI_SLAVE_RX_OVERRUN_EN
  assign rx_overrun = r_rx_overrun;
`endif

endmodule

// File: tb/tb_spi_slave_shifter.sv
// Directed bench for spi_slave_shifter: a mode-0 DUT checked every cycle against a transaction-level
// model, plus a CPOL=1/CPHA=1 DUT checked with literal expectations.
module tb_spi_slave_shifter;

  localparam int H = 6;  // master half-bit period in clk cycles

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       phase = 1'b0;
  logic       mosi = 1'b0;
  logic       ss0 = 1'b1;
  logic       ss3 = 1'b1;
  logic       sclk0, sclk3;
  logic [7:0] tx_data = 8'h00;
  logic       tx_load0 = 1'b0, tx_load3 = 1'b0;
  logic       rx_ack0 = 1'b0, rx_ack3 = 1'b0;

  logic       miso0, oe0, txe0, rxv0, busy0;
  logic [7:0] rxd0;
  logic       miso3, oe3, txe3, rxv3, busy3;
  logic [7:0] rxd3;
`ifdef SPI_SLAVE_RX_OVERRUN_EN
  logic       ovr0, ovr3;
`endif

  assign sclk0 = phase;
  assign sclk3 = ~phase;

  spi_slave_shifter #(.WORD_LENGTH(8), .CPOL(1'b0), .CPHA(1'b0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .SCLK(sclk0), .MOSI(mosi), .SSbar(ss0), .MISO(miso0),
    .miso_oe(oe0), .tx_data(tx_data), .tx_load(tx_load0), .tx_empty(txe0), .rx_data(rxd0),
    .rx_valid(rxv0), .rx_ack(rx_ack0), .busy(busy0)
`ifdef SPI_SLAVE_RX_OVERRUN_EN
    , .rx_overrun(ovr0)
`endif
  );

  spi_slave_shifter #(.WORD_LENGTH(8), .CPOL(1'b1), .CPHA(1'b1)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .SCLK(sclk3), .MOSI(mosi), .SSbar(ss3), .MISO(miso3),
    .miso_oe(oe3), .tx_data(tx_data), .tx_load(tx_load3), .tx_empty(txe3), .rx_data(rxd3),
    .rx_valid(rxv3), .rx_ack(rx_ack3), .busy(busy3)
`ifdef SPI_SLAVE_RX_OVERRUN_EN
    , .rx_overrun(ovr3)
`endif
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int chk_hold = 1;

  // Model of the mode-0 DUT at transaction level.
  logic       m_rx_valid = 1'b0;
  logic [7:0] m_rx_data = 8'h00;
  logic       m_tx_empty = 1'b1;
  logic [7:0] m_tx_hold = 8'h00;
  logic       m_busy = 1'b0;
  logic       m_overrun = 1'b0;
  logic [7:0] m_tx_exp [3];
  logic [15:0] mi;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic m_take(output logic [7:0] v);
    v = m_tx_empty ? 8'h00 : m_tx_hold;
    m_tx_empty = 1'b1;
  endtask

  task automatic m_word_done(input logic [7:0] w);
`ifdef SPI_SLAVE_RX_OVERRUN_EN
    if (m_rx_valid) begin
      m_overrun = 1'b1;
    end else begin
      m_rx_data  = w;
      m_rx_valid = 1'b1;
    end
`else
    m_rx_data  = w;
    m_rx_valid = 1'b1;
`endif
  endtask

  task automatic pulse_load(input logic [7:0] v);
    chk_hold++;
    tx_data  = v;
    tx_load0 = 1'b1;
    wait_clk(1);
    tx_load0   = 1'b0;
    m_tx_hold  = v;
    m_tx_empty = 1'b0;
    wait_clk(1);
    chk_hold--;
  endtask

  task automatic pulse_ack();
    chk_hold++;
    rx_ack0 = 1'b1;
    wait_clk(1);
    rx_ack0    = 1'b0;
    m_rx_valid = 1'b0;
    m_overrun  = 1'b0;
    wait_clk(1);
    chk_hold--;
  endtask

  // One SS-low frame of n bits (MSB of mo first); m3 selects the CPOL=1/CPHA=1 DUT.
  task automatic frame(input bit m3, input int n, input logic [15:0] mo, input bit lat,
                       output logic [15:0] mi_o);
    logic [23:0] exp_cat;
    logic [7:0]  w;
    mi_o = '0;
    m_tx_exp = '{default: 8'h00};
    chk_hold++;
    if (m3) ss3 = 1'b0;
    else ss0 = 1'b0;
    mosi = m3 ? 1'b0 : mo[n-1];
    wait_clk(H);
    if (!m3) begin
      m_take(m_tx_exp[0]);
      m_busy = 1'b1;
    end
    chk_hold--;
    for (int i = 0; i < n; i++) begin
      if (!m3) begin
        if (i % 8 == 7) chk_hold++;
        mi_o[n-1-i] = miso0;
        phase = 1'b1;
        if (lat && i == n - 1) begin
          wait_clk(3);
          check("rx_valid 3clk after last edge", rxv0, 0);
          wait_clk(1);
          check("rx_valid 4clk after last edge", rxv0, 1);
          wait_clk(H - 4);
        end else begin
          wait_clk(H);
        end
        phase = 1'b0;
        if (i + 1 < n) mosi = mo[n-2-i];
        wait_clk(H);
        if (i % 8 == 7) begin
          w = 8'(mo >> (n - 1 - i));
          m_word_done(w);
          m_take(m_tx_exp[(i / 8) + 1]);
          chk_hold--;
        end
      end else begin
        phase = 1'b1;
        mosi  = mo[n-1-i];
        wait_clk(H);
        mi_o[n-1-i] = miso3;
        phase = 1'b0;
        wait_clk(H);
      end
    end
    chk_hold++;
    ss0  = 1'b1;
    ss3  = 1'b1;
    mosi = 1'b0;
    wait_clk(4);
    if (m3) check("busy3 4clk after deselect", busy3, 0);
    else check("busy0 4clk after deselect", busy0, 0);
    wait_clk(H - 4);
    if (!m3) begin
      m_busy  = 1'b0;
      exp_cat = {m_tx_exp[0], m_tx_exp[1], m_tx_exp[2]};
      check("miso stream vs model", mi_o, 32'(16'(exp_cat >> (24 - n))));
    end
    chk_hold--;
  endtask

  always @(negedge clk) begin
    if (chk_hold == 0) begin
      check("rx_valid", rxv0, m_rx_valid);
      check("rx_data", rxd0, m_rx_data);
      check("tx_empty", txe0, m_tx_empty);
      check("busy", busy0, m_busy);
      check("miso_oe", oe0, m_busy);
      if (!m_busy) check("miso idle", miso0, 0);
`ifdef SPI_SLAVE_RX_OVERRUN_EN
      check("rx_overrun", ovr0, m_overrun);
`endif
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: bench did not reach its end, %0d vectors so far", n_vec);
    $fatal(1, "watchdog expired");
  end

  initial begin
    wait_clk(3);
    check("reset MISO", miso0, 0);
    check("reset miso_oe", oe0, 0);
    check("reset tx_empty", txe0, 1);
    check("reset rx_data", rxd0, 0);
    check("reset rx_valid", rxv0, 0);
    check("reset busy", busy0, 0);
    rst_n = 1'b1;
    wait_clk(2);
    chk_hold = 0;

    // Mode 0: tx 0xA5, master sends 0x3C.
    pulse_load(8'hA5);
    frame(1'b0, 8, 16'h003C, 1'b1, mi);
    check("t1 miso bits", mi[7:0], 8'hA5);
    check("t1 rx_data", rxd0, 8'h3C);
    check("t1 rx_valid", rxv0, 1);
    check("t1 tx_empty", txe0, 1);
    pulse_ack();

    // CPOL=1/CPHA=1: tx 0x81, master sends 0xF0; mode-0 DUT sees edges while deselected.
    tx_data  = 8'h81;
    tx_load3 = 1'b1;
    wait_clk(1);
    tx_load3 = 1'b0;
    frame(1'b1, 8, 16'h00F0, 1'b0, mi);
    check("t2 master rx", mi[7:0], 8'h81);
    check("t2 rx_data", rxd3, 8'hF0);
    check("t2 rx_valid", rxv3, 1);

    // Two back-to-back words; second tx word loaded mid-first-word, ack between.
    pulse_load(8'h11);
    fork
      frame(1'b0, 16, 16'hC396, 1'b0, mi);
      begin
        wait_clk(40);
        pulse_load(8'h22);
        wait_clk(88);
        check("t3 rx_valid word1", rxv0, 1);
        check("t3 rx_data word1", rxd0, 8'hC3);
        pulse_ack();
        check("t3 rx_valid acked", rxv0, 0);
      end
    join
    check("t3 miso words", mi, 16'h1122);
    check("t3 rx_data word2", rxd0, 8'h96);
    check("t3 rx_valid word2", rxv0, 1);
    pulse_ack();

    // Abort after 5 bits of 0xFF, then a full 0x5A with nothing loaded (MISO all zeros).
    frame(1'b0, 5, 16'h001F, 1'b0, mi);
    check("t4 rx_valid after abort", rxv0, 0);
    check("t4 tx_empty after abort", txe0, 1);
    frame(1'b0, 8, 16'h005A, 1'b0, mi);
    check("t5 rx_data", rxd0, 8'h5A);
    check("t5 miso zeros", mi[7:0], 8'h00);
    check("t5 tx_empty", txe0, 1);

    // Second word 0x77 while 0x5A is still unread.
    frame(1'b0, 8, 16'h0077, 1'b0, mi);
`ifdef SPI_SLAVE_RX_OVERRUN_EN
    check("t6 rx_data kept", rxd0, 8'h5A);
    check("t6 rx_overrun", ovr0, 1);
    pulse_ack();
    check("t6 rx_valid cleared", rxv0, 0);
    check("t6 rx_overrun cleared", ovr0, 0);
`else
    check("t6 rx_data overwritten", rxd0, 8'h77);
    check("t6 rx_valid", rxv0, 1);
`endif

    // Asynchronous reset in the middle of a selected transfer.
    pulse_load(8'h99);
    chk_hold++;
    ss0 = 1'b0;
    wait_clk(8);
    check("t7 busy before reset", busy0, 1);
    #2 rst_n = 1'b0;
    #1;
    check("t7 busy in reset", busy0, 0);
    check("t7 miso_oe in reset", oe0, 0);
    check("t7 MISO in reset", miso0, 0);
    check("t7 tx_empty in reset", txe0, 1);
    check("t7 rx_valid in reset", rxv0, 0);
    check("t7 rx_data in reset", rxd0, 0);
    ss0 = 1'b1;
    wait_clk(2);
    rst_n = 1'b1;
    wait_clk(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
